// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round counts, encipher FSM
// state encodings and the GF(2^8) / ShiftRows helpers.
// The key memory imports the same key-length constants.
package aes_pkg;

    localparam logic [1:0] AES_128_BIT_KEY = 2'd0;
    localparam logic [1:0] AES_192_BIT_KEY = 2'd1;
    localparam logic [1:0] AES_256_BIT_KEY = 2'd2;

    localparam logic [3:0] AES128_ROUNDS = 4'd10;
    localparam logic [3:0] AES192_ROUNDS = 4'd12;
    localparam logic [3:0] AES256_ROUNDS = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SBOX  = 3'd2,
        ST_MAIN  = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } enc_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // Row r of the column-major state rotates left by r byte positions.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_encipher_block_if.sv
// Bus between the encipher datapath and its host, key memory and shared S-box.
// slave: the encipher block; master: the surrounding logic driving it.
interface aes_encipher_block_if;
    logic         next;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic         ready;
    logic [127:0] result;

    modport master (
        output next, keylen, block, round_key, new_sboxw,
        input  round, sboxw, ready, result
    );

    modport slave (
        input  next, keylen, block, round_key, new_sboxw,
        output round, sboxw, ready, result
    );
endinterface

// File: rtl/aes_mixcolumns.sv
// Combinational ShiftRows followed by MixColumns over the full 128-bit state.
import aes_pkg::*;

module aes_mixcolumns (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    logic [127:0] w_sr;

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gm2(a0) ^ gm3(a1) ^ a2 ^ a3,
                a0 ^ gm2(a1) ^ gm3(a2) ^ a3,
                a0 ^ a1 ^ gm2(a2) ^ gm3(a3),
                gm3(a0) ^ a1 ^ a2 ^ gm2(a3)};
    endfunction

    assign w_sr = shift_rows(i_state);

    // Mix each shifted column independently.
    always_comb begin
        o_state = '0;
        for (int c = 0; c < 4; c++) begin
            o_state[127 - 32*c -: 32] = mix_word(w_sr[127 - 32*c -: 32]);
        end
    end
endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES forward cipher. Indexes the round-key memory with a 4-bit
// round number and substitutes one state word per cycle through a shared
// 32-bit S-box port.
// Build option: AES_ENC_KEYLEN_192_EN enables keylen=1 -> 12 rounds; without
// it keylen=1 runs as a 10-round job.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready; next captures block and keylen
// ST_INIT  | round 0 AddRoundKey
// ST_SBOX  | SubBytes, one word per cycle, word_ctr 0..3
// ST_MAIN  | ShiftRows+MixColumns+AddRoundKey, advance round
// ST_FINAL | last round ShiftRows+AddRoundKey
// ST_DONE  | publish result, raise ready
import aes_pkg::*;

module aes_encipher_block (
    input  logic               clk,
    input  logic               reset,
    aes_encipher_block_if.slave bus
);
    enc_state_t   r_state, w_state_next;
    logic [127:0] r_data;
    logic [127:0] r_result;
    logic [3:0]   r_round_ctr;
    logic [3:0]   r_nr;
    logic [1:0]   r_word_ctr;
    logic         r_ready;

    logic [127:0] w_mix;
    logic [127:0] w_sr;
    logic [127:0] w_sbox_data;
    logic [31:0]  w_word;
    logic [3:0]   w_nr_sel;

    aes_mixcolumns u_mixcolumns (
        .i_state (r_data),
        .o_state (w_mix)
    );

    assign w_sr       = shift_rows(r_data);
    assign bus.ready  = r_ready;
    assign bus.result = r_result;

    // Round count from the requested key length; code 3 runs as 256-bit.
    always_comb begin
        w_nr_sel = AES256_ROUNDS;
        if (bus.keylen == AES_128_BIT_KEY) begin
            w_nr_sel = AES128_ROUNDS;
        end
`ifdef AES_ENC_KEYLEN_192_EN
        else if (bus.keylen == AES_192_BIT_KEY) begin
            w_nr_sel = AES192_ROUNDS;
        end
`else
        else if (bus.keylen == AES_192_BIT_KEY) begin
            w_nr_sel = AES128_ROUNDS;
        end
`endif
    end

    // Select the word being substituted and splice the S-box answer back in.
    always_comb begin
        w_word      = r_data[127:96];
        w_sbox_data = r_data;
        case (r_word_ctr)
            2'd0: begin w_word = r_data[127:96]; w_sbox_data[127:96] = bus.new_sboxw; end
            2'd1: begin w_word = r_data[95:64];  w_sbox_data[95:64]  = bus.new_sboxw; end
            2'd2: begin w_word = r_data[63:32];  w_sbox_data[63:32]  = bus.new_sboxw; end
            default: begin w_word = r_data[31:0]; w_sbox_data[31:0]  = bus.new_sboxw; end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the key-memory index and S-box word presented this cycle.
    always_comb begin
        w_state_next = r_state;
        bus.round    = r_round_ctr;
        bus.sboxw    = r_data[127:96];
        case (r_state)
            ST_IDLE:  if (bus.next) w_state_next = ST_INIT;
            ST_INIT: begin
                bus.round    = 4'd0;
                w_state_next = ST_SBOX;
            end
            ST_SBOX: begin
                bus.sboxw = w_word;
                if (r_word_ctr == 2'd3) begin
                    w_state_next = (r_round_ctr == r_nr) ? ST_FINAL : ST_MAIN;
                end
            end
            ST_MAIN:  w_state_next = ST_SBOX;
            ST_FINAL: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Cipher state, counters and result/ready registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_result    <= '0;
            r_round_ctr <= '0;
            r_nr        <= '0;
            r_word_ctr  <= '0;
            r_ready     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.next) begin
                        r_data  <= bus.block;
                        r_nr    <= w_nr_sel;
                        r_ready <= 1'b0;
                    end
                end
                ST_INIT: begin
                    r_data      <= r_data ^ bus.round_key;
                    r_round_ctr <= 4'd1;
                    r_word_ctr  <= 2'd0;
                end
                ST_SBOX: begin
                    r_data     <= w_sbox_data;
                    r_word_ctr <= r_word_ctr + 2'd1;
                end
                ST_MAIN: begin
                    r_data      <= w_mix ^ bus.round_key;
                    r_round_ctr <= r_round_ctr + 4'd1;
                    r_word_ctr  <= 2'd0;
                end
                ST_FINAL: begin
                    r_data <= w_sr ^ bus.round_key;
                end
                ST_DONE: begin
                    r_ready  <= 1'b1;
                    r_result <= r_data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_encipher_block.sv
// Self-checking bench for aes_encipher_block. The bench plays key memory and
// S-box, and compares against a byte-matrix AES reference model.
module tb_aes_encipher_block;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    aes_encipher_block_if bus();

    aes_encipher_block dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef AES_ENC_KEYLEN_192_EN
    localparam int KL1_NR = 12;
`else
    localparam int KL1_NR = 10;
`endif

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_mem [15];
    int n_tests = 0;
    int n_fail  = 0;

    assign bus.round_key = (bus.round < 4'd15) ? rk_mem[bus.round] : '0;
    assign bus.new_sboxw = {sbox_t[bus.sboxw[31:24]], sbox_t[bus.sboxw[23:16]],
                            sbox_t[bus.sboxw[15:8]],  sbox_t[bus.sboxw[7:0]]};

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 60; i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < 15; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic int model_nr(input logic [1:0] kl);
        case (kl)
            2'd0:    return 10;
            2'd1:    return KL1_NR;
            default: return 14;
        endcase
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] k, o;
        k = rk_mem[0];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ k[127 - 8*(4*c + r) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            k = rk_mem[rnd];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sbox_t[s[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd < nr)
                        s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^
                                  t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ k[127 - 8*(4*c + r) -: 8];
                end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[r][c];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One job: start, watch round sequence and latency, check result and hold.
    // poke_at re-pulses next and scrambles block mid-run; rst_at aborts the run.
    task automatic run_job(input string tag, input logic [1:0] kl, input int nk,
                           input logic [255:0] key, input logic [127:0] pt,
                           input int poke_at, input int rst_at, output logic [127:0] res);
        int nr, j, rerr, drops;
        logic [127:0] exp;
        logic [3:0]   exp_r;
        bit done;
        expand_key(key, nk);
        nr  = model_nr(kl);
        exp = ref_encrypt(pt, nr);
        res = '0;
        @(negedge clk);
        bus.next = 1'b1; bus.keylen = kl; bus.block = pt;
        @(negedge clk);
        bus.next = 1'b0;
        j = 0; rerr = 0; done = 0;
        while (!done && j < 200) begin
            exp_r = (j == 0) ? 4'd0 : 4'((j - 1) / 5 + 1);
            if (j <= 5*nr && bus.round !== exp_r) rerr++;
            if (bus.ready === 1'b1) begin
                done = 1;
            end else begin
                if (j == rst_at) begin
                    reset = 1'b1;
                    @(negedge clk);
                    check_eq({tag, "_rst_ready"},  128'(bus.ready),  128'd1);
                    check_eq({tag, "_rst_result"}, bus.result,       128'd0);
                    check_eq({tag, "_rst_round"},  128'(bus.round),  128'd0);
                    reset = 1'b0;
                    @(negedge clk);
                    return;
                end
                if (j == poke_at) begin
                    bus.next = 1'b1; bus.block = rand128(); bus.keylen = ~kl;
                end else begin
                    bus.next = 1'b0;
                end
                @(negedge clk);
                j++;
            end
        end
        bus.next = 1'b0;
        check_eq({tag, "_latency"},   128'(j),    128'(2 + 5*nr));
        check_eq({tag, "_round_seq"}, 128'(rerr), 128'd0);
        check_eq({tag, "_result"},    bus.result, exp);
        check_eq({tag, "_sboxw_idle"}, 128'(bus.sboxw), 128'(exp[127:96]));
        res = bus.result;
        drops = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ready !== 1'b1 || bus.result !== exp) drops++;
        end
        check_eq({tag, "_hold"}, 128'(drops), 128'd0);
    endtask

    initial begin
        logic [127:0] res;
        logic [1:0]   kl;
        reset = 1'b1;
        bus.next = 1'b0; bus.keylen = 2'd0; bus.block = '0;
        for (int i = 0; i < 256; i++) sbox_t[i] = calc_sbox(8'(i));
        for (int r = 0; r < 15; r++) rk_mem[r] = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_ready",  128'(bus.ready), 128'd1);
        check_eq("reset_result", bus.result,      128'd0);
        check_eq("reset_round",  128'(bus.round), 128'd0);
        check_eq("reset_sboxw",  128'(bus.sboxw), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        run_job("c1", 2'd0, 4, K128, PT, -1, -1, res);
        check_eq("c1_fips", res, C1);
        run_job("c2", 2'd1, 6, K192, PT, -1, -1, res);
`ifdef AES_ENC_KEYLEN_192_EN
        check_eq("c2_fips", res, C2);
`endif
        run_job("c3", 2'd2, 8, K256, PT, -1, -1, res);
        check_eq("c3_fips", res, C3);
        run_job("c3_kl3", 2'd3, 8, K256, PT, -1, -1, res);
        check_eq("c3_kl3_fips", res, C3);

        run_job("poke", 2'd0, 4, K128, PT, 20, -1, res);
        check_eq("poke_fips", res, C1);

        run_job("abort", 2'd2, 8, K256, PT, -1, 30, res);
        run_job("c1_after_rst", 2'd0, 4, K128, PT, -1, -1, res);
        check_eq("c1_after_rst_fips", res, C1);

        for (int n = 0; n < 6; n++) begin
            kl = 2'($urandom_range(0, 3));
            run_job($sformatf("rand%0d", n), kl, (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8,
                    {rand128(), rand128()}, rand128(), -1, -1, res);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
